// File: rtl/usb_bit_rx_param_if.sv
// usb_bit_rx_param_if: raw D+/D- pins, speed mode and decoded bit/event strobes of the USB bit receiver.
// Latency: none, wires only.
// Backpressure: none; all strobes are single-cycle pulses that the consumer must take when they occur.
interface usb_bit_rx_param_if;
    logic       rx_dp;
    logic       rx_dn;
    logic       low_speed;
    logic       rx_active;
    logic       rx_start;
    logic       rx_valid;
    logic       rx_bit;
    logic       rx_finish;
    logic       rx_error;
    logic [2:0] err_code;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;

    // Receiver side: takes the pins, produces the decoded stream.
    modport master (
        input  rx_dp, rx_dn, low_speed,
        output rx_active, rx_start, rx_valid, rx_bit, rx_finish, rx_error,
        output err_code, rx_byte, rx_byte_valid
    );

    // Pin driver / packet layer side.
    modport slave (
        output rx_dp, rx_dn, low_speed,
        input  rx_active, rx_start, rx_valid, rx_bit, rx_finish, rx_error,
        input  err_code, rx_byte, rx_byte_valid
    );
endinterface

// File: rtl/usb_bit_rx_param.sv
// usb_bit_rx_param: oversampled USB bit receiver (NRZI decode, SYNC, destuff, EOP, error codes); USB_RX_BYTE_ASM_EN adds byte assembly.
// Latency: rx_valid 3 + CLK_PER_BIT/2 clk after the raw line edge (2-FF sync, mid-bit sample, output register).
// Backpressure: none; bits stream at line rate and every strobe is a one-cycle pulse.
module usb_bit_rx_param #(
    parameter int CLK_PER_BIT  = 5,
    parameter int STUFF_LEN    = 6,
    parameter int IDLE_BITS    = 8,
    parameter int MAX_SE0_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    usb_bit_rx_param_if.master bus
);
    localparam int PH_W   = $clog2(CLK_PER_BIT);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);
    localparam int SE0_W  = $clog2(MAX_SE0_BITS + 2);

    localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(CLK_PER_BIT / 2);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_PER_BIT - 1);
    localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(STUFF_LEN);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);
    localparam logic [SE0_W-1:0]  SE0_MAX   = SE0_W'(MAX_SE0_BITS);

    localparam logic [2:0] ERR_SYNC  = 3'd1;
    localparam logic [2:0] ERR_STUFF = 3'd2;
    localparam logic [2:0] ERR_SE1   = 3'd3;
    localparam logic [2:0] ERR_EOP   = 3'd4;

    typedef enum logic [2:0] {ST_WAIT_IDLE, ST_IDLE, ST_SYNC, ST_DATA, ST_EOP} state_t;
    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_t;

    // Front end
    logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            sample;
    logic            mode_eff;
    line_t           line_st;

    // FSM state and registered outputs
    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    line_t             ref_q, ref_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [2:0]        sidx_q, sidx_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [SE0_W-1:0]  se0_q, se0_d;
    logic              active_q, active_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic              bit_q, bit_d;
    logic              finish_q, finish_d;
    logic              error_q, error_d;
    logic [2:0]        code_q, code_d;

    // Per-cycle temporaries of the FSM
    logic       fail;
    logic [2:0] fail_code;
    logic       dbit;
    logic       resid;
    line_t      sync_exp;

`ifdef USB_RX_BYTE_ASM_EN
    logic [7:0] byte_q, byte_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       bvalid_q, bvalid_d;
`endif

    // Synchroniser, phase realignment on every line edge, mid-bit sample strobe and line-state decode.
    always_comb begin
        sync1_d = {bus.rx_dp, bus.rx_dn};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (sync2_q != prev_q) begin
            phase_d = '0;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
        sample = (phase_d == PH_SAMPLE);
        // While waiting for idle the pin is followed live so the idle J is judged in the new polarity.
        mode_eff = ((state_q == ST_WAIT_IDLE) || (state_q == ST_IDLE)) ? bus.low_speed : mode_q;
        case (sync2_q)
            2'b10:   line_st = mode_eff ? LS_K : LS_J;
            2'b01:   line_st = mode_eff ? LS_J : LS_K;
            2'b00:   line_st = LS_SE0;
            default: line_st = LS_SE1;
        endcase
    end

    // Packet FSM: idle qualification, SYNC match, NRZI/destuff, EOP and error reporting.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ref_d     = ref_q;
        idle_d    = idle_q;
        sidx_d    = sidx_q;
        ones_d    = ones_q;
        se0_d     = se0_q;
        active_d  = active_q;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        bit_d     = bit_q;
        finish_d  = 1'b0;
        error_d   = 1'b0;
        code_d    = code_q;
        fail      = 1'b0;
        fail_code = 3'd0;
        dbit      = (line_st == ref_q);
        sync_exp  = ((sidx_q == 3'd6) || sidx_q[0]) ? LS_K : LS_J;
`ifdef USB_RX_BYTE_ASM_EN
        byte_d    = byte_q;
        bcnt_d    = bcnt_q;
        bvalid_d  = 1'b0;
        resid     = (bcnt_q != 3'd0);
`else
        resid     = 1'b0;
`endif
        if ((state_q == ST_WAIT_IDLE) || (state_q == ST_IDLE)) begin
            mode_d = bus.low_speed;
        end

        if (sample) begin
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (line_st != LS_J) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_LAST) begin
                        idle_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (line_st == LS_K) begin
                        sidx_d  = 3'd0;
                        state_d = ST_SYNC;
                    end else if (line_st != LS_J) begin
                        idle_d  = '0;
                        state_d = ST_WAIT_IDLE;
                    end
                end
                ST_SYNC: begin
                    if (line_st != sync_exp) begin
                        fail      = 1'b1;
                        fail_code = ERR_SYNC;
                    end else if (sidx_q == 3'd6) begin
                        start_d  = 1'b1;
                        active_d = 1'b1;
                        code_d   = 3'd0;
                        ref_d    = LS_K;
                        ones_d   = '0;
                        state_d  = ST_DATA;
`ifdef USB_RX_BYTE_ASM_EN
                        bcnt_d   = 3'd0;
`endif
                    end else begin
                        sidx_d = sidx_q + 3'd1;
                    end
                end
                ST_DATA: begin
                    case (line_st)
                        LS_J, LS_K: begin
                            ref_d = line_st;
                            if (ones_q == ONES_MAX) begin
                                // Mandatory stuff position: a transition is dropped, a repeat is illegal.
                                if (dbit) begin
                                    fail      = 1'b1;
                                    fail_code = ERR_STUFF;
                                end else begin
                                    ones_d = '0;
                                end
                            end else begin
                                valid_d = 1'b1;
                                bit_d   = dbit;
                                ones_d  = dbit ? (ones_q + ONES_W'(1)) : '0;
`ifdef USB_RX_BYTE_ASM_EN
                                byte_d   = {dbit, byte_q[7:1]};
                                bcnt_d   = bcnt_q + 3'd1;
                                bvalid_d = (bcnt_q == 3'd7);
`endif
                            end
                        end
                        LS_SE0: begin
                            se0_d   = SE0_W'(1);
                            state_d = ST_EOP;
                        end
                        default: begin
                            fail      = 1'b1;
                            fail_code = ERR_SE1;
                        end
                    endcase
                end
                ST_EOP: begin
                    case (line_st)
                        LS_SE0: begin
                            if (se0_q == SE0_MAX) begin
                                fail      = 1'b1;
                                fail_code = ERR_EOP;
                            end else begin
                                se0_d = se0_q + SE0_W'(1);
                            end
                        end
                        LS_J: begin
                            // A packet that ends mid-byte is reported as a bad EOP.
                            if (resid) begin
                                fail      = 1'b1;
                                fail_code = ERR_EOP;
                            end else begin
                                finish_d = 1'b1;
                                active_d = 1'b0;
                                state_d  = ST_IDLE;
                            end
                        end
                        LS_K: begin
                            fail      = 1'b1;
                            fail_code = ERR_EOP;
                        end
                        default: begin
                            fail      = 1'b1;
                            fail_code = ERR_SE1;
                        end
                    endcase
                end
                default: begin
                    state_d = ST_WAIT_IDLE;
                    idle_d  = '0;
                end
            endcase
        end

        if (fail) begin
            error_d  = 1'b1;
            code_d   = fail_code;
            active_d = 1'b0;
            idle_d   = '0;
            state_d  = ST_WAIT_IDLE;
        end
    end

    // All state and outputs registered; reset drops any packet in flight without pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            prev_q   <= 2'b00;
            phase_q  <= '0;
            state_q  <= ST_WAIT_IDLE;
            mode_q   <= 1'b0;
            ref_q    <= LS_J;
            idle_q   <= '0;
            sidx_q   <= 3'd0;
            ones_q   <= '0;
            se0_q    <= '0;
            active_q <= 1'b0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            bit_q    <= 1'b0;
            finish_q <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 3'd0;
`ifdef USB_RX_BYTE_ASM_EN
            byte_q   <= 8'd0;
            bcnt_q   <= 3'd0;
            bvalid_q <= 1'b0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            phase_q  <= phase_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            ref_q    <= ref_d;
            idle_q   <= idle_d;
            sidx_q   <= sidx_d;
            ones_q   <= ones_d;
            se0_q    <= se0_d;
            active_q <= active_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            bit_q    <= bit_d;
            finish_q <= finish_d;
            error_q  <= error_d;
            code_q   <= code_d;
`ifdef USB_RX_BYTE_ASM_EN
            byte_q   <= byte_d;
            bcnt_q   <= bcnt_d;
            bvalid_q <= bvalid_d;
`endif
        end
    end

    assign bus.rx_active = active_q;
    assign bus.rx_start  = start_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_bit    = bit_q;
    assign bus.rx_finish = finish_q;
    assign bus.rx_error  = error_q;
    assign bus.err_code  = code_q;
`ifdef USB_RX_BYTE_ASM_EN
    assign bus.rx_byte       = byte_q;
    assign bus.rx_byte_valid = bvalid_q;
`else
    assign bus.rx_byte       = 8'd0;
    assign bus.rx_byte_valid = 1'b0;
`endif
endmodule
